// File: rtl/mfp_srec_word_coalescer.sv
// Coalesces the S-record parser's byte-write stream into AHB-Lite word writes, or
// per-byte writes for partial words, through a small pending-word FIFO.
module mfp_srec_word_coalescer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        big_endian,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  input  logic        flush,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WORD = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [29:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;

  logic [29:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [3:0]  fifo_mask_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  logic [3:0]  done_q, done_d;
  logic [31:0] hwdata_q;
  logic        dphase_q;
  logic        overflow_q;

  logic        fifo_full, need_evict, push, pop, ovf_set;
  logic [1:0]  in_lane;
  logic [3:0]  in_bit;

  logic        head_valid;
  logic [29:0] head_addr;
  logic [31:0] head_data;
  logic [3:0]  head_mask;
  logic [1:0]  state;
  logic [3:0]  rem;
  logic [1:0]  iss_lane, byte_off;
  logic [3:0]  iss_bit;
  logic        last_byte;

  assign in_lane   = big_endian ? (2'd3 - write_address[1:0]) : write_address[1:0];
  assign in_bit    = 4'b0001 << in_lane;
  assign fifo_full = (count_q == (PW+1)'(FIFO_DEPTH));

  // A full buffer, a write to another word, or a flush forces eviction; when the FIFO
  // cannot take it the buffer stays put and the incoming byte/flush is discarded.
  always_comb begin
    need_evict = (mask_q == 4'hF) ||
                 ((mask_q != '0) && ((write_enable && (write_address[31:2] != waddr_q)) || flush));
    push    = need_evict && !fifo_full;
    ovf_set = need_evict && fifo_full && (write_enable || flush);
    waddr_d = waddr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (push) begin
      mask_d = '0;
      if (write_enable) begin
        waddr_d = write_address[31:2];
        data_d  = '0;
        data_d[{in_lane, 3'b000} +: 8] = write_byte;
        mask_d  = in_bit;
      end
    end else if (!need_evict && write_enable) begin
      if (mask_q == '0) begin
        waddr_d = write_address[31:2];
        data_d  = '0;
      end
      data_d[{in_lane, 3'b000} +: 8] = write_byte;
      mask_d = mask_d | in_bit;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_mask  = fifo_mask_q[rd_ptr_q];
  assign rem        = head_mask & ~done_q;

  always_comb begin
    if (!head_valid)            state = ST_IDLE;
    else if (head_mask == 4'hF) state = ST_WORD;
    else                        state = ST_BYTE;
  end

  always_comb begin
    iss_lane = 2'd0;
    if (rem[0])      iss_lane = 2'd0;
    else if (rem[1]) iss_lane = 2'd1;
    else if (rem[2]) iss_lane = 2'd2;
    else if (rem[3]) iss_lane = 2'd3;
  end

  assign iss_bit   = 4'b0001 << iss_lane;
  assign last_byte = ((rem & ~iss_bit) == '0);
  assign byte_off  = big_endian ? (2'd3 - iss_lane) : iss_lane;

  // Address phase is driven straight from the FIFO head so it holds while HREADY=0.
  always_comb begin
    HTRANS = TR_IDLE;
    HADDR  = '0;
    HSIZE  = '0;
    HWRITE = 1'b0;
    case (state)
      ST_WORD: begin
        HTRANS = TR_NONSEQ;
        HADDR  = {head_addr, 2'b00};
        HSIZE  = 3'b010;
        HWRITE = 1'b1;
      end
      ST_BYTE: begin
        HTRANS = TR_NONSEQ;
        HADDR  = {head_addr, byte_off};
        HSIZE  = 3'b000;
        HWRITE = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pop    = HREADY && ((state == ST_WORD) || ((state == ST_BYTE) && last_byte));
    done_d = done_q;
    if (HREADY && (state == ST_BYTE)) begin
      done_d = last_byte ? '0 : (done_q | iss_bit);
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= waddr_q;
      fifo_data_q[wr_ptr_q] <= data_q;
      fifo_mask_q[wr_ptr_q] <= mask_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      waddr_q    <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= '0;
      hwdata_q   <= '0;
      dphase_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_q | ovf_set;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (HREADY) begin
        if (state != ST_IDLE) hwdata_q <= head_data;
        dphase_q <= (state != ST_IDLE);
      end
    end
  end

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign HWDATA    = hwdata_q;
  assign overflow  = overflow_q;
  assign busy      = (mask_q != '0) || head_valid || (state != ST_IDLE) || dphase_q;

endmodule
